// File: rtl/subsystem_bus_slave_pkg.sv
// Shared bus constants and the handshake state encoding for the subsystem bus slave.
package subsystem_bus_slave_pkg;

  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 8;
  localparam int INDEX_W        = 4;
  localparam int WORDS_PER_READ = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLATCH,
    S_WACK,
    S_RWAIT,
    S_RDRIVE,
    S_RACK,
    S_RDONE
  } slaveStateT;

endpackage

// File: rtl/subsystem_bus_slave_register_bank.sv
// NUM_REGS x 32-bit register storage: one indexed write port, flat read-out,
// and an asynchronous clear.
module subsystem_register_bank
  import subsystem_bus_slave_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       writeEnable,
  input  logic [INDEX_W-1:0]         writeIndex,
  input  logic [DATA_W-1:0]          writeData,
  output logic [NUM_REGS*DATA_W-1:0] regQ
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: clear on reset, otherwise load only the addressed register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (writeEnable) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (writeIndex == INDEX_W'(k)) regs[k] <= writeData;
      end
    end
  end

  // Flatten the array so register k sits at bits [32k+31:32k].
  always_comb begin
    regQ = '0;
    for (int k = 0; k < NUM_REGS; k++) regQ[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule

// File: rtl/subsystem_bus_slave.sv
// Internal-bus slave: one write followed by two read words per transaction,
// paced by a four-phase strobe/acknowledge handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for an armed, selected strobe
// S_WLATCH | register and write_index just loaded; write_strobe high
// S_WACK   | write acknowledged; waiting for strobe low
// S_RWAIT  | waiting for the next read strobe
// S_RDRIVE | read word captured into the output register
// S_RACK   | read acknowledged, data held; waiting for strobe low
// S_RDONE  | word finished; loop for the next word or return to idle
module subsystem_bus_slave
  import subsystem_bus_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] REG_BASE = 8'h00,
  parameter int                NUM_REGS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          bus_addr,
  input  logic [DATA_W-1:0]          bus_data_in,
  input  logic                       bus_handshake_1,
  output logic                       bus_handshake_2,
  output logic [DATA_W-1:0]          bus_data_out,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       write_strobe,
  output logic [INDEX_W-1:0]         write_index,
  input  logic [DATA_W-1:0]          status_in
);

  // Compare one bit wider than the address so a window ending at 8'hFF
  // does not wrap around and claim 8'h00.
  localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, REG_BASE};
  localparam logic [ADDR_W:0] LIMIT_EXT = BASE_EXT + (ADDR_W+1)'(NUM_REGS);

  slaveStateT         state;
  slaveStateT         nextState;
  logic               armed;
  logic               wordCnt;
  logic               lastWord;
  logic               writeEn;
  logic               selected;
  logic [ADDR_W:0]    addrExt;
  logic [INDEX_W-1:0] reqIndex;
  logic [DATA_W-1:0]  regWord;
  logic [DATA_W-1:0]  readWord;

  assign addrExt  = {1'b0, bus_addr};
  assign selected = (addrExt >= BASE_EXT) && (addrExt < LIMIT_EXT);
  assign reqIndex = INDEX_W'(bus_addr - REG_BASE);
  assign lastWord = (int'(wordCnt) == WORDS_PER_READ - 1);

  subsystem_register_bank #(
    .NUM_REGS (NUM_REGS)
  ) registerBank (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEn),
    .writeIndex  (reqIndex),
    .writeData   (bus_data_in),
    .regQ        (reg_q)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nextState;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    nextState       = state;
    bus_handshake_2 = 1'b0;
    write_strobe    = 1'b0;
    writeEn         = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && bus_handshake_1 && selected) begin
          writeEn   = 1'b1;
          nextState = S_WLATCH;
        end
      end
      S_WLATCH: begin
        write_strobe = 1'b1;
        nextState    = S_WACK;
      end
      S_WACK: begin
        bus_handshake_2 = 1'b1;
        if (!bus_handshake_1) nextState = S_RWAIT;
      end
      S_RWAIT: begin
        if (bus_handshake_1) nextState = S_RDRIVE;
      end
      S_RDRIVE: begin
        nextState = S_RACK;
      end
      S_RACK: begin
        bus_handshake_2 = 1'b1;
        if (!bus_handshake_1) nextState = S_RDONE;
      end
      S_RDONE: begin
        nextState = lastWord ? S_IDLE : S_RWAIT;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // Arm only once the strobe has been seen low, so a strobe held high
  // through reset release cannot start a transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     armed <= 1'b0;
    else if (state == S_IDLE && !bus_handshake_1)   armed <= 1'b1;
  end

  // Remember which register the current transaction wrote; read word 0 uses it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       write_index <= '0;
    else if (writeEn) write_index <= reqIndex;
  end

  // Read word counter, advanced once per completed read word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                wordCnt <= 1'b0;
    else if (state == S_RDONE) wordCnt <= lastWord ? 1'b0 : wordCnt + 1'b1;
  end

  // Read mux: word 0 is the last-written register, word 1 is live status.
  always_comb begin
    regWord = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (write_index == INDEX_W'(k)) regWord = reg_q[k*DATA_W +: DATA_W];
    end
    readWord = (wordCnt == 1'b0) ? regWord : status_in;
  end

  // Output data register: capture in S_RDRIVE, hold through the ack,
  // and return to zero whenever the slave stops driving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                            bus_data_out <= '0;
    else if (state == S_RDRIVE)                            bus_data_out <= readWord;
    else if (nextState == S_RWAIT || nextState == S_IDLE)  bus_data_out <= '0;
  end

endmodule

// File: tb/tb_subsystem_bus_slave.sv
// Two slaves share one bus (windows 0x10..0x13 and 0xFC..0xFF); a master
// task drives transactions and checks against an array model of the registers.
module tb_subsystem_bus_slave;
  import subsystem_bus_slave_pkg::*;

  localparam logic [7:0] BASE_A = 8'h10;
  localparam logic [7:0] BASE_B = 8'hFC;
  localparam int         NREG   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hs1 = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] dataIn = '0;
  logic [31:0] status = '0;

  logic             hs2    [2];
  logic [31:0]      dout   [2];
  logic [NREG*32-1:0] regQ [2];
  logic             strobe [2];
  logic [3:0]       wIdx   [2];
  logic             hs2Bus;
  logic [31:0]      doutBus;

  int   checks = 0;
  int   failures = 0;
  int   strobeTot = 0;
  int   ackEdges = 0;
  logic hs2Prev = 1'b0;
  logic [31:0] model [2][NREG];

  assign hs2Bus  = hs2[0] | hs2[1];
  assign doutBus = dout[0] | dout[1];

  always #5 clk = ~clk;

  subsystem_bus_slave #(.REG_BASE(BASE_A), .NUM_REGS(NREG)) dutA (
    .clk(clk), .reset(reset), .bus_addr(addr), .bus_data_in(dataIn),
    .bus_handshake_1(hs1), .bus_handshake_2(hs2[0]), .bus_data_out(dout[0]),
    .reg_q(regQ[0]), .write_strobe(strobe[0]), .write_index(wIdx[0]),
    .status_in(status));

  subsystem_bus_slave #(.REG_BASE(BASE_B), .NUM_REGS(NREG)) dutB (
    .clk(clk), .reset(reset), .bus_addr(addr), .bus_data_in(dataIn),
    .bus_handshake_1(hs1), .bus_handshake_2(hs2[1]), .bus_data_out(dout[1]),
    .reg_q(regQ[1]), .write_strobe(strobe[1]), .write_index(wIdx[1]),
    .status_in(status));

  // Count write pulses and acknowledge rising edges seen on the bus.
  always @(negedge clk) begin
    strobeTot = strobeTot + int'(strobe[0]) + int'(strobe[1]);
    if (hs2Bus && !hs2Prev) ackEdges = ackEdges + 1;
    hs2Prev = hs2Bus;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic waitLvl(input logic lvl, input string tag);
    int n = 0;
    while (hs2Bus !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (hs2Bus === lvl) else begin
      failures++;
      $error("FAIL timeout_%s observed=%b expected=%b", tag, hs2Bus, lvl);
    end
  endtask

  task automatic dly(input int maxDly);
    repeat (int'($urandom_range(0, maxDly))) @(negedge clk);
  endtask

  // Which slave owns an address: plain integer window arithmetic.
  function automatic int selWhich(input logic [7:0] a);
    int v = int'(a);
    if (v >= int'(BASE_A) && v < int'(BASE_A) + NREG) return 0;
    if (v >= int'(BASE_B) && v < int'(BASE_B) + NREG) return 1;
    return -1;
  endfunction

  task automatic clearModel();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < NREG; k++) model[w][k] = '0;
  endtask

  task automatic chkRegs(input string tag);
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < NREG; k++)
        chk($sformatf("%s_reg%0d_%0d", tag, w, k), regQ[w][k*32 +: 32], model[w][k]);
  endtask

  task automatic txn(input logic [7:0] a, input logic [31:0] d, input int maxDly);
    int who, idx, s0, e0;
    logic [31:0] st, expWord, seenData;
    logic seenHs2;
    who = selWhich(a);
    @(negedge clk);
    s0 = strobeTot;
    e0 = ackEdges;
    addr = a;
    dataIn = d;
    dly(maxDly);
    hs1 = 1'b1;
    if (who < 0) begin
      seenHs2 = 1'b0;
      seenData = '0;
      repeat (12) begin
        @(negedge clk);
        seenHs2 = seenHs2 | hs2Bus;
        seenData = seenData | doutBus;
      end
      hs1 = 1'b0;
      @(negedge clk);
      chk("ign_hs2", 32'(seenHs2), 32'd0);
      chk("ign_dout", seenData, 32'd0);
      chk("ign_strobe", 32'(strobeTot - s0), 32'd0);
      chkRegs("ign");
    end else begin
      idx = int'(a) - ((who == 0) ? int'(BASE_A) : int'(BASE_B));
      model[who][idx] = d;
      waitLvl(1'b1, "wack");
      chk("wr_reg", regQ[who][idx*32 +: 32], d);
      chk("wr_index", 32'(wIdx[who]), 32'(idx));
      chk("wr_strobe", 32'(strobeTot - s0), 32'd1);
      chk("wack_dout", doutBus, 32'd0);
      dly(maxDly);
      hs1 = 1'b0;
      waitLvl(1'b0, "wack_rel");
      chk("rwait_dout", doutBus, 32'd0);
      for (int w = 0; w < 2; w++) begin
        dly(maxDly);
        st = $urandom;
        status = st;
        hs1 = 1'b1;
        waitLvl(1'b1, "rack");
        expWord = (w == 0) ? d : st;
        chk($sformatf("rd_word%0d", w), doutBus, expWord);
        status = $urandom;
        dly(maxDly);
        chk($sformatf("rd_hold%0d", w), doutBus, expWord);
        hs1 = 1'b0;
        waitLvl(1'b0, "rack_rel");
        @(negedge clk);
        chk($sformatf("rd_clear%0d", w), doutBus, 32'd0);
      end
      chk("end_state", (who == 0) ? 32'(dutA.state) : 32'(dutB.state), 32'(S_IDLE));
      chk("ack_count", 32'(ackEdges - e0), 32'd3);
      chk("strobe_total", 32'(strobeTot - s0), 32'd1);
    end
  endtask

  initial begin
    logic seenHs2;
    int pick;
    logic [7:0] a;
    clearModel();

    // Asynchronous reset, applied with no clock edge involved.
    #2 reset = 1'b0;
    #1;
    chk("rst_hs2", 32'(hs2Bus), 32'd0);
    chk("rst_dout", doutBus, 32'd0);
    chk("rst_strobe", 32'(strobe[0] | strobe[1]), 32'd0);
    chk("rst_windex", 32'({wIdx[0], wIdx[1]}), 32'd0);
    chkRegs("rst");

    // Strobe held high through reset release must not be accepted.
    addr = 8'h12;
    dataIn = 32'h1111_2222;
    hs1 = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    seenHs2 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seenHs2 = seenHs2 | hs2Bus;
    end
    chk("held_hs2", 32'(seenHs2), 32'd0);
    chk("held_strobe", 32'(strobeTot), 32'd0);
    chkRegs("held");
    hs1 = 1'b0;
    repeat (2) @(negedge clk);

    // Directed write/read of base+2, then out-of-window and wrap cases.
    txn(8'h12, 32'hDEAD_BEEF, 0);
    txn(8'h14, 32'h5555_AAAA, 0);
    txn(8'hFF, 32'hCAFE_F00D, 0);
    txn(8'h00, 32'h0BAD_0BAD, 0);
    txn(8'hFB, 32'h7777_7777, 0);

    // Reset while the slave is holding read data in the acknowledge phase.
    @(negedge clk);
    addr = 8'h11;
    dataIn = 32'hA5A5_0001;
    hs1 = 1'b1;
    waitLvl(1'b1, "abort_wack");
    hs1 = 1'b0;
    waitLvl(1'b0, "abort_wrel");
    status = 32'h0000_1234;
    hs1 = 1'b1;
    waitLvl(1'b1, "abort_rack");
    chk("abort_pre", doutBus, 32'hA5A5_0001);
    reset = 1'b0;
    #1;
    clearModel();
    chk("abort_hs2", 32'(hs2Bus), 32'd0);
    chk("abort_dout", doutBus, 32'd0);
    chkRegs("abort");
    hs1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    txn(8'h11, 32'h0F0F_1234, 0);

    // Randomised addresses, data and handshake delays of 0..7 cycles.
    for (int i = 0; i < 14; i++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 4)       a = BASE_A + 8'(pick);
      else if (pick < 8)  a = BASE_B + 8'(pick - 4);
      else if (pick == 8) a = 8'h14;
      else                a = 8'h00;
      txn(a, $urandom, 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
